// File: rtl/gate_truth_checker_if.sv
// Bus between the gate truth checker and its environment (gate under test, LEDs, start button).
// Optional GATE_CHECKER_CAPTURE_EN adds the tt_observed capture field.
interface gate_truth_checker_if;
  logic       start;
  logic       gate_out;
  logic       drv_a;
  logic       drv_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [1:0] vec_idx;
`ifdef GATE_CHECKER_CAPTURE_EN
  logic [3:0] tt_observed;
`endif

`ifdef GATE_CHECKER_CAPTURE_EN
  // Checker side
  modport master (
    input  start, gate_out,
    output drv_a, drv_b, busy, done, pass, fail_mask, vec_idx, tt_observed
  );
  // Environment side
  modport slave (
    output start, gate_out,
    input  drv_a, drv_b, busy, done, pass, fail_mask, vec_idx, tt_observed
  );
`else
  modport master (
    input  start, gate_out,
    output drv_a, drv_b, busy, done, pass, fail_mask, vec_idx
  );
  modport slave (
    output start, gate_out,
    input  drv_a, drv_b, busy, done, pass, fail_mask, vec_idx
  );
`endif
endinterface

// File: rtl/gate_truth_checker.sv
// Drives all four input pairs into a two-input gate, samples its output through a
// 2-flop synchronizer and checks it against EXPECT_TT. Optional: GATE_CHECKER_CAPTURE_EN.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  EXPECT_TT     = 4'b0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_truth_checker_if.master  bus
);

  // Floor of 3 covers the two synchronizer stages plus the gate settling.
  localparam int unsigned EFF_SETTLE = (SETTLE_CYCLES < 3) ? 3 : SETTLE_CYCLES;
  localparam int unsigned CNT_W      = (EFF_SETTLE > 1) ? $clog2(EFF_SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EFF_SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [3:0]       fail_q;
  logic             sync_meta;
  logic             gate_sync;
  logic             mismatch_c;
  logic [3:0]       fail_next_c;
`ifdef GATE_CHECKER_CAPTURE_EN
  logic [3:0]       tt_q;
`endif

  // Two-flop synchronizer for the asynchronous gate output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      gate_sync <= 1'b0;
    end else begin
      sync_meta <= bus.gate_out;
      gate_sync <= sync_meta;
    end
  end

  assign mismatch_c  = (gate_sync != EXPECT_TT[vec_q]);
  assign fail_next_c = fail_q | (4'(mismatch_c) << vec_q);

  // Sequencer: hold each vector, sample once, accumulate mismatches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      vec_q  <= 2'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 4'd0;
`ifdef GATE_CHECKER_CAPTURE_EN
      tt_q   <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 4'd0;
            vec_q  <= 2'd0;
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
            state  <= SETTLE;
`ifdef GATE_CHECKER_CAPTURE_EN
            tt_q   <= 4'd0;
`endif
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SAMPLE: begin
          fail_q <= fail_next_c;
`ifdef GATE_CHECKER_CAPTURE_EN
          tt_q[vec_q] <= gate_sync;
`endif
          if (vec_q == 2'd3) begin
            // Vector 3's compare is folded into pass on this same edge
            done_q <= 1'b1;
            busy_q <= 1'b0;
            pass_q <= (fail_next_c == 4'd0);
            state  <= IDLE;
          end else begin
            vec_q <= vec_q + 2'd1;
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.drv_a     = vec_q[1];
  assign bus.drv_b     = vec_q[0];
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_q;
`ifdef GATE_CHECKER_CAPTURE_EN
  assign bus.tt_observed = tt_q;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: NOR/AND/stuck gate models, reset, start handling,
// minimum settle clamp. Also checks tt_observed when GATE_CHECKER_CAPTURE_EN is defined.
module tb_gate_truth_checker;

  logic clk;
  logic rst_n;
  logic [1:0] model;   // 0 NOR, 1 AND, 2 stuck 0, 3 stuck 1
  int assertions;
  int failures;

  gate_truth_checker_if bus ();
  gate_truth_checker_if bus_s1 ();

  gate_truth_checker #(.SETTLE_CYCLES(4), .EXPECT_TT(4'b0001)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  gate_truth_checker #(.SETTLE_CYCLES(1), .EXPECT_TT(4'b0001)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s1)
  );

  assign bus.gate_out = (model == 2'd0) ? ~(bus.drv_a | bus.drv_b) :
                        (model == 2'd1) ?  (bus.drv_a & bus.drv_b) :
                        (model == 2'd2) ? 1'b0 : 1'b1;
  assign bus_s1.gate_out = ~(bus_s1.drv_a | bus_s1.drv_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; edges counts posedges after the accepting edge until done (-1 on timeout)
  task automatic start_and_wait(input bit use_s1, output int edges);
    int i;
    edges = -1;
    i = 0;
    @(negedge clk);
    if (use_s1) bus_s1.start = 1'b1; else bus.start = 1'b1;
    @(posedge clk); #1;
    bus_s1.start = 1'b0;
    bus.start = 1'b0;
    while (edges < 0 && i < 100) begin
      @(posedge clk); #1;
      i++;
      if ((use_s1 ? bus_s1.done : bus.done) === 1'b1) edges = i;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    assertions++;
    if ({bus.drv_a, bus.drv_b, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.vec_idx} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {bus.drv_a, bus.drv_b, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.vec_idx});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    assertions++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL idle_without_start: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_nor_pass;
    int edges;
    model = 2'd0;
    start_and_wait(1'b0, edges);
    assertions++;
    if (edges !== 20) begin
      failures++;
      $display("FAIL nor_done_latency: got %0d edges expected 20", edges);
    end
    assertions++;
    if (bus.pass !== 1'b1 || bus.fail_mask !== 4'b0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL nor_result: pass=%b mask=%b busy=%b expected 1 0000 0", bus.pass, bus.fail_mask, bus.busy);
    end
    assertions++;
    if (bus.drv_a !== 1'b1 || bus.drv_b !== 1'b1 || bus.vec_idx !== 2'd3) begin
      failures++;
      $display("FAIL nor_final_vector: a=%b b=%b idx=%0d expected 1 1 3", bus.drv_a, bus.drv_b, bus.vec_idx);
    end
`ifdef GATE_CHECKER_CAPTURE_EN
    assertions++;
    if (bus.tt_observed !== 4'b0001) begin
      failures++;
      $display("FAIL nor_tt_observed: got %b expected 0001", bus.tt_observed);
    end
`endif
  endtask

  task automatic test_and_model;
    int edges;
    model = 2'd1;
    start_and_wait(1'b0, edges);
    assertions++;
    if (edges !== 20 || bus.fail_mask !== 4'b1001 || bus.pass !== 1'b0) begin
      failures++;
      $display("FAIL and_result: edges=%0d mask=%b pass=%b expected 20 1001 0", edges, bus.fail_mask, bus.pass);
    end
`ifdef GATE_CHECKER_CAPTURE_EN
    assertions++;
    if (bus.tt_observed !== 4'b1000) begin
      failures++;
      $display("FAIL and_tt_observed: got %b expected 1000", bus.tt_observed);
    end
`endif
  endtask

  task automatic test_stuck;
    int edges;
    model = 2'd2;
    start_and_wait(1'b0, edges);
    assertions++;
    if (edges !== 20 || bus.fail_mask !== 4'b0001 || bus.pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck0_result: edges=%0d mask=%b pass=%b expected 20 0001 0", edges, bus.fail_mask, bus.pass);
    end
    model = 2'd3;
    start_and_wait(1'b0, edges);
    assertions++;
    if (edges !== 20 || bus.fail_mask !== 4'b1110 || bus.pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck1_result: edges=%0d mask=%b pass=%b expected 20 1110 0", edges, bus.fail_mask, bus.pass);
    end
  endtask

  task automatic test_reset_midrun;
    int i;
    int edges;
    model = 2'd1;
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    i = 0;
    while (bus.vec_idx !== 2'd2 && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    assertions++;
    if (bus.vec_idx !== 2'd2 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_reach_vec2: idx=%0d busy=%b expected 2 1", bus.vec_idx, bus.busy);
    end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    assertions++;
    if ({bus.drv_a, bus.drv_b, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.vec_idx} !== 11'd0) begin
      failures++;
      $display("FAIL midrun_async_reset: got %b expected all zero",
               {bus.drv_a, bus.drv_b, bus.busy, bus.done, bus.pass, bus.fail_mask, bus.vec_idx});
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model = 2'd0;
    start_and_wait(1'b0, edges);
    assertions++;
    if (edges !== 20 || bus.pass !== 1'b1 || bus.fail_mask !== 4'b0000) begin
      failures++;
      $display("FAIL post_reset_run: edges=%0d pass=%b mask=%b expected 20 1 0000", edges, bus.pass, bus.fail_mask);
    end
  endtask

  task automatic test_ignore_start;
    int i;
    int edges;
    model = 2'd0;
    edges = -1;
    i = 0;
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    while (edges < 0 && i < 100) begin
      @(posedge clk); #1;
      i++;
      if (i == 6) bus.start = 1'b1;
      if (i == 7) bus.start = 1'b0;
      if (bus.done === 1'b1) edges = i;
    end
    assertions++;
    if (edges !== 20 || bus.fail_mask !== 4'b0000 || bus.pass !== 1'b1) begin
      failures++;
      $display("FAIL ignore_start: edges=%0d mask=%b pass=%b expected 20 0000 1", edges, bus.fail_mask, bus.pass);
    end
  endtask

  task automatic test_back_to_back;
    int i;
    int edges;
    model = 2'd1;
    edges = -1;
    i = 0;
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk); #1;
    while (edges < 0 && i < 100) begin
      @(posedge clk); #1;
      i++;
      if (bus.done === 1'b1) edges = i;
    end
    assertions++;
    if (edges !== 20 || bus.fail_mask !== 4'b1001 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL held_start_first_run: edges=%0d mask=%b busy=%b expected 20 1001 0", edges, bus.fail_mask, bus.busy);
    end
    @(posedge clk); #1;
    assertions++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.fail_mask !== 4'b0000 || bus.vec_idx !== 2'd0) begin
      failures++;
      $display("FAIL held_start_restart: done=%b busy=%b mask=%b idx=%0d expected 0 1 0000 0",
               bus.done, bus.busy, bus.fail_mask, bus.vec_idx);
    end
    bus.start = 1'b0;
    i = 0;
    while (bus.done !== 1'b1 && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    assertions++;
    if (bus.done !== 1'b1 || bus.fail_mask !== 4'b1001) begin
      failures++;
      $display("FAIL held_start_second_run: done=%b mask=%b expected 1 1001", bus.done, bus.fail_mask);
    end
  endtask

  task automatic test_min_settle;
    int edges;
    start_and_wait(1'b1, edges);
    assertions++;
    if (edges !== 16 || bus_s1.pass !== 1'b1 || bus_s1.fail_mask !== 4'b0000) begin
      failures++;
      $display("FAIL min_settle: edges=%0d pass=%b mask=%b expected 16 1 0000", edges, bus_s1.pass, bus_s1.fail_mask);
    end
  endtask

  initial begin
    assertions = 0;
    failures = 0;
    model = 2'd0;
    bus.start = 1'b0;
    bus_s1.start = 1'b0;
    test_reset();
    test_nor_pass();
    test_and_model();
    test_stuck();
    test_reset_midrun();
    test_ignore_start();
    test_back_to_back();
    test_min_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
